// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller with byte FIFO, error flags and guarded baud switching.
//
// Ports:
//   clk_in       single clock, all logic on the rising edge
//   reset_n      asynchronous active-low reset
//   rx_busy      receiver is mid-frame
//   rx_done      one-cycle pulse, byte complete
//   rx_data      received byte, valid with rx_done
//   rx_stop      sampled stop bit, valid with rx_done
//   baud_req     request to apply baud_sel_in
//   baud_sel_in  requested baud select
//   baud_sel     baud select driven to the receiver
//   rx_enable    receiver enable, low for GUARD cycles while a new baud is applied
//   m_valid      FIFO head valid
//   m_data       FIFO head byte
//   m_ready      consumer accepts head
//   fifo_level   occupied FIFO entries
//   overrun      sticky: byte dropped because the FIFO was full
//   frame_err    sticky: byte discarded because the stop bit was 0
//   clr_err      clears the sticky flags (and err_cnt)
//   err_cnt      saturating error event counter, only with UART_RX_ERR_CNT_EN defined
//
// Optional feature macro: UART_RX_ERR_CNT_EN adds the err_cnt port and its counter.
module uart_rx_ctrl #(
    parameter int DEPTH = 4,
    parameter int GUARD = 16,
    parameter int CNT_W = 8
) (
    input  logic                       clk_in,
    input  logic                       reset_n,
    input  logic                       rx_busy,
    input  logic                       rx_done,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_stop,
    input  logic                       baud_req,
    input  logic [1:0]                 baud_sel_in,
    output logic [1:0]                 baud_sel,
    output logic                       rx_enable,
    output logic                       m_valid,
    output logic [7:0]                 m_data,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overrun,
    output logic                       frame_err,
    input  logic                       clr_err
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]           err_cnt
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GUARD + 1);

    typedef enum logic [1:0] {RUN, DRAIN, SWITCH} state_t;

    state_t        state, state_nxt;
    logic [1:0]    lat, lat_nxt;
    logic [GW-1:0] guard, guard_nxt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          accept, pop, full, push, frame_ev, overrun_ev;

    // ---------------- baud switch FSM ----------------
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            lat   <= 2'b00;
            guard <= '0;
        end else begin
            state <= state_nxt;
            lat   <= lat_nxt;
            guard <= guard_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lat_nxt   = lat;
        guard_nxt = '0;
        case (state)
            RUN: begin
                if (baud_req) begin
                    lat_nxt   = baud_sel_in;
                    state_nxt = rx_busy ? DRAIN : SWITCH;
                end
            end
            DRAIN: begin
                if (!rx_busy) state_nxt = SWITCH;
            end
            SWITCH: begin
                // guard counts the SWITCH cycles already spent; leave after GUARD of them
                guard_nxt = guard + GW'(1);
                if (guard == GW'(GUARD - 1)) begin
                    state_nxt = RUN;
                    guard_nxt = '0;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign rx_enable = (state != SWITCH);

    // The new baud select is applied on the same edge that enters SWITCH, so the
    // receiver sees it together with rx_enable dropping.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) baud_sel <= 2'b00;
        else if (state != SWITCH && state_nxt == SWITCH) baud_sel <= lat_nxt;
    end

    // ---------------- byte acceptance ----------------
    assign accept     = rx_done && (state != SWITCH);
    assign pop        = m_valid && m_ready;
    assign full       = (fifo_level == LW'(DEPTH));
    // a pop in the same cycle frees the slot, so a full FIFO can still take the byte
    assign push       = accept && rx_stop && (!full || pop);
    assign overrun_ev = accept && rx_stop && full && !pop;
    assign frame_ev   = accept && !rx_stop;

    // ---------------- FIFO ----------------
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    assign m_valid = (fifo_level != '0);
    assign m_data  = mem[rd_ptr];

    // ---------------- sticky error flags ----------------
    // a new event wins over a simultaneous clear
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= overrun_ev || (overrun && !clr_err);
            frame_err <= frame_ev || (frame_err && !clr_err);
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // frame and overrun events are mutually exclusive, so at most one count per cycle
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) err_cnt <= '0;
        else if (frame_ev || overrun_ev) err_cnt <= clr_err ? CNT_W'(1) : (&err_cnt ? err_cnt : err_cnt + CNT_W'(1));
        else if (clr_err) err_cnt <= '0;
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: table-driven, hand-sequenced and randomized checks of uart_rx_ctrl.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;
    localparam int GUARD = 16;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk_in = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_busy = 1'b0;
    logic          rx_done = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_stop = 1'b0;
    logic          baud_req = 1'b0;
    logic [1:0]    baud_sel_in = 2'b00;
    logic [1:0]    baud_sel;
    logic          rx_enable;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_ready = 1'b0;
    logic [LW-1:0] fifo_level;
    logic          overrun;
    logic          frame_err;
    logic          clr_err = 1'b0;
`ifdef UART_RX_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    always #5 clk_in = ~clk_in;

    uart_rx_ctrl #(.DEPTH(DEPTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .rx_busy(rx_busy), .rx_done(rx_done),
        .rx_data(rx_data), .rx_stop(rx_stop), .baud_req(baud_req), .baud_sel_in(baud_sel_in),
        .baud_sel(baud_sel), .rx_enable(rx_enable), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .fifo_level(fifo_level), .overrun(overrun), .frame_err(frame_err),
        .clr_err(clr_err)
`ifdef UART_RX_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_in(input logic busy, input logic done, input logic [7:0] data, input logic stop,
                          input logic req, input logic [1:0] sel, input logic ready, input logic clr);
        rx_busy = busy; rx_done = done; rx_data = data; rx_stop = stop;
        baud_req = req; baud_sel_in = sel; m_ready = ready; clr_err = clr;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_ec(input string name, input int exp);
`ifdef UART_RX_ERR_CNT_EN
        check(name, 32'(err_cnt), 32'(exp));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 0);
        check({tag, "_level"}, 32'(fifo_level), 0);
        check({tag, "_baud_sel"}, 32'(baud_sel), 0);
        check({tag, "_rx_enable"}, 32'(rx_enable), 1);
        check({tag, "_overrun"}, 32'(overrun), 0);
        check({tag, "_frame_err"}, 32'(frame_err), 0);
        check_ec({tag, "_err_cnt"}, 0);
    endtask

    // ---------------- table vectors (FIFO and error behaviour) ----------------
    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       stop;
        logic       ready;
        logic       clr;
        logic       mv;
        logic [7:0] md;
        int         lvl;
        logic       ov;
        logic       fe;
        int         ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic done, input logic [7:0] data, input logic stop, input logic ready,
                               input logic clr, input logic mv, input logic [7:0] md, input int lvl,
                               input logic ov, input logic fe, input int ec);
        vec_t r;
        r.done = done; r.data = data; r.stop = stop; r.ready = ready; r.clr = clr;
        r.mv = mv; r.md = md; r.lvl = lvl; r.ov = ov; r.fe = fe; r.ec = ec;
        return r;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [7:0] q[$];
    int         mode;   // 0 running, 1 waiting for idle receiver, 2 guarded switch
    int         left;
    logic [1:0] pend, bsel;
    logic       mdl_ov, mdl_fe;
    int         mdl_ec;

    task automatic model_reset();
        q.delete();
        mode = 0; left = 0; pend = 2'b00; bsel = 2'b00;
        mdl_ov = 1'b0; mdl_fe = 1'b0; mdl_ec = 0;
    endtask

    task automatic model_step();
        bit pop_m, acc, fe, ov, ps;
        pop_m = (q.size() > 0) && m_ready;
        acc   = rx_done && (mode != 2);
        fe    = acc && !rx_stop;
        ov    = acc && rx_stop && (q.size() == DEPTH) && !pop_m;
        ps    = acc && rx_stop && !ov;
        if (pop_m) void'(q.pop_front());
        if (ps) q.push_back(rx_data);
        mdl_ov = ov || (mdl_ov && !clr_err);
        mdl_fe = fe || (mdl_fe && !clr_err);
        if (fe || ov) mdl_ec = clr_err ? 1 : ((mdl_ec == (1 << CNT_W) - 1) ? mdl_ec : mdl_ec + 1);
        else if (clr_err) mdl_ec = 0;
        if (mode == 0 && baud_req) begin
            pend = baud_sel_in;
            mode = rx_busy ? 1 : 2;
            if (mode == 2) begin left = GUARD; bsel = pend; end
        end else if (mode == 1 && !rx_busy) begin
            mode = 2; left = GUARD; bsel = pend;
        end else if (mode == 2) begin
            left--;
            if (left == 0) mode = 0;
        end
    endtask

    task automatic check_model();
        check("rnd_m_valid", 32'(m_valid), 32'(q.size() > 0));
        if (q.size() > 0) check("rnd_m_data", 32'(m_data), 32'(q[0]));
        check("rnd_level", 32'(fifo_level), 32'(q.size()));
        check("rnd_overrun", 32'(overrun), 32'(mdl_ov));
        check("rnd_frame_err", 32'(frame_err), 32'(mdl_fe));
        check("rnd_rx_enable", 32'(rx_enable), 32'(mode != 2));
        check("rnd_baud_sel", 32'(baud_sel), 32'(bsel));
        check_ec("rnd_err_cnt", mdl_ec);
    endtask

    initial begin
        // ---- reset ----
        reset_n = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        check_reset_vals("in_reset");
        @(negedge clk_in);
        reset_n = 1'b1;
        tick();
        check_reset_vals("after_reset");

        // ---- table: single byte, overflow, pop+push when full, framing, clear races ----
        tbl.push_back(v(1, 8'hA5, 1, 0, 0, 1, 8'hA5, 1, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h01, 1, 0, 0, 1, 8'h01, 1, 0, 0, 0));
        tbl.push_back(v(1, 8'h02, 1, 0, 0, 1, 8'h01, 2, 0, 0, 0));
        tbl.push_back(v(1, 8'h03, 1, 0, 0, 1, 8'h01, 3, 0, 0, 0));
        tbl.push_back(v(1, 8'h04, 1, 0, 0, 1, 8'h01, 4, 0, 0, 0));
        tbl.push_back(v(1, 8'h05, 1, 0, 0, 1, 8'h01, 4, 1, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h02, 3, 1, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h03, 2, 1, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h04, 1, 1, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h01, 1, 0, 0, 1, 8'h01, 1, 0, 0, 0));
        tbl.push_back(v(1, 8'h02, 1, 0, 0, 1, 8'h01, 2, 0, 0, 0));
        tbl.push_back(v(1, 8'h03, 1, 0, 0, 1, 8'h01, 3, 0, 0, 0));
        tbl.push_back(v(1, 8'h04, 1, 0, 0, 1, 8'h01, 4, 0, 0, 0));
        tbl.push_back(v(1, 8'h05, 1, 1, 0, 1, 8'h02, 4, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h03, 3, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h04, 2, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h05, 1, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h3C, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h3C, 0, 0, 1, 0, 8'h00, 0, 0, 1, 1));
        tbl.push_back(v(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(v(1, 8'h01, 1, 0, 0, 1, 8'h01, 1, 0, 0, 0));
        tbl.push_back(v(1, 8'h02, 1, 0, 0, 1, 8'h01, 2, 0, 0, 0));
        tbl.push_back(v(1, 8'h03, 1, 0, 0, 1, 8'h01, 3, 0, 0, 0));
        tbl.push_back(v(1, 8'h04, 1, 0, 0, 1, 8'h01, 4, 0, 0, 0));
        tbl.push_back(v(1, 8'h3C, 0, 0, 0, 1, 8'h01, 4, 0, 1, 1));
        tbl.push_back(v(0, 8'h00, 0, 1, 1, 1, 8'h02, 3, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h03, 2, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 1, 8'h04, 1, 0, 0, 0));
        tbl.push_back(v(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0));
        foreach (tbl[i]) begin
            set_in(0, tbl[i].done, tbl[i].data, tbl[i].stop, 0, 2'b00, tbl[i].ready, tbl[i].clr);
            tick();
            check($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(tbl[i].mv));
            if (tbl[i].mv) check($sformatf("tbl%0d_m_data", i), 32'(m_data), 32'(tbl[i].md));
            check($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'(tbl[i].ov));
            check($sformatf("tbl%0d_frame_err", i), 32'(frame_err), 32'(tbl[i].fe));
            check($sformatf("tbl%0d_rx_enable", i), 32'(rx_enable), 1);
            check($sformatf("tbl%0d_baud_sel", i), 32'(baud_sel), 0);
            check_ec($sformatf("tbl%0d_err_cnt", i), tbl[i].ec);
        end

        // ---- baud switch while busy ----
        set_in(1, 0, 8'h00, 0, 1, 2'b10, 0, 0);
        tick();
        check("drain_rx_enable", 32'(rx_enable), 1);
        check("drain_baud_sel", 32'(baud_sel), 2'b00);
        set_in(1, 1, 8'h77, 1, 1, 2'b01, 0, 0);
        tick();
        check("drain_push_level", 32'(fifo_level), 1);
        check("drain_push_data", 32'(m_data), 8'h77);
        check("drain_baud_hold", 32'(baud_sel), 2'b00);
        set_in(0, 0, 8'h00, 0, 0, 2'b00, 0, 0);
        tick();
        check("switch_baud_sel", 32'(baud_sel), 2'b10);
        check("switch_rx_enable", 32'(rx_enable), 0);
        for (int i = 1; i < GUARD; i++) begin
            set_in(0, i == 3 || i == 5, (i == 3) ? 8'h11 : 8'h22, i != 5, i == 7, 2'b11, 0, 0);
            tick();
            check($sformatf("guard%0d_rx_enable", i), 32'(rx_enable), 0);
            check($sformatf("guard%0d_level", i), 32'(fifo_level), 1);
            check($sformatf("guard%0d_frame_err", i), 32'(frame_err), 0);
            check($sformatf("guard%0d_baud_sel", i), 32'(baud_sel), 2'b10);
        end
        set_in(0, 0, 8'h00, 0, 0, 2'b00, 0, 0);
        tick();
        check("guard_end_rx_enable", 32'(rx_enable), 1);
        check("guard_end_baud_sel", 32'(baud_sel), 2'b10);
        check("guard_end_data", 32'(m_data), 8'h77);
        set_in(0, 0, 8'h00, 0, 0, 2'b00, 1, 0);
        tick();
        check("guard_end_pop", 32'(m_valid), 0);

        // ---- reset in the middle of a switch with bytes queued ----
        set_in(0, 1, 8'h11, 1, 0, 2'b00, 0, 0); tick();
        set_in(0, 1, 8'h22, 1, 0, 2'b00, 0, 0); tick();
        set_in(0, 1, 8'h99, 0, 0, 2'b00, 0, 0); tick();
        check("pre_rst_level", 32'(fifo_level), 2);
        check("pre_rst_frame_err", 32'(frame_err), 1);
        set_in(0, 0, 8'h00, 0, 1, 2'b01, 0, 0); tick();
        check("pre_rst_rx_enable", 32'(rx_enable), 0);
        check("pre_rst_baud_sel", 32'(baud_sel), 2'b01);
        set_in(0, 0, 8'h00, 0, 0, 2'b00, 0, 0);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk_in);
        reset_n = 1'b1;
        tick();
        check_reset_vals("post_rst");

        // ---- randomized run against the reference model ----
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rx_busy     = ($urandom_range(0, 9) < 3);
            rx_done     = ($urandom_range(0, 2) == 0);
            rx_data     = 8'($urandom);
            rx_stop     = ($urandom_range(0, 7) != 0);
            baud_req    = ($urandom_range(0, 29) == 0);
            baud_sel_in = 2'($urandom);
            m_ready     = ((i / 200) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            clr_err     = ($urandom_range(0, 19) == 0);
            model_step();
            tick();
            check_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
